// File: rtl/spt_pkt_chk.sv
// Packet checker: frames dv runs on the selected rx port and emits one classification pulse per packet.
// Optional macro SPT_PORT_B_EN enables the port A/B mux and switch-abort logic.
module spt_pkt_chk #(
  parameter int unsigned MIN_LEN = 8,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 12
) (
  input  logic       clk_50m,
  input  logic       rst_core_n,
  input  logic       cpuif_port_sel,
  input  logic       rxa_dv,
  input  logic [7:0] rxa_data,
  input  logic       rxb_dv,
  input  logic [7:0] rxb_data,
  output logic       spt_cpuif_head_err,
  output logic       spt_cpuif_tail_err,
  output logic       spt_cpuif_short_pkt,
  output logic       spt_cpuif_long_pkt,
  output logic       spt_cpuif_ok_pkt,
  output logic       spt_busy
);

  localparam logic [LEN_W-1:0] CNT_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_LEN + 1);

  typedef enum logic [1:0] {ST_GAP, ST_IDLE, ST_HEAD, ST_BODY} state_e;

  logic       dv;
  logic [7:0] data;
  logic       port_switch;

`ifdef SPT_PORT_B_EN
  logic sel_q;

  always_ff @(posedge clk_50m or negedge rst_core_n) begin
    if (!rst_core_n) sel_q <= 1'b0;
    else             sel_q <= cpuif_port_sel;
  end

  assign dv          = cpuif_port_sel ? rxb_dv   : rxa_dv;
  assign data        = cpuif_port_sel ? rxb_data : rxa_data;
  assign port_switch = cpuif_port_sel ^ sel_q;
`else
  logic unused_port_b;
  assign unused_port_b = &{1'b0, cpuif_port_sel, rxb_dv, rxb_data};
  assign dv          = rxa_dv;
  assign data        = rxa_data;
  assign port_switch = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             hdr_bad_q, hdr_bad_d;
  logic [15:0]      last_q, last_d;
  logic             end_pkt;
  // pulse_d order: head, short, long, tail, ok
  logic [4:0]       pulse_d;

  // Next-state, framing datapath and end-of-packet classification
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_bad_d = hdr_bad_q;
    last_d    = last_q;
    end_pkt   = 1'b0;
    pulse_d   = 5'b0;

    case (state_q)
      ST_GAP: begin
        if (!dv) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (dv) begin
          state_d   = ST_HEAD;
          cnt_d     = LEN_W'(1);
          hdr_bad_d = (data != 8'h55);
          last_d    = {last_q[7:0], data};
        end
      end
      ST_HEAD: begin
        if (dv) begin
          state_d   = ST_BODY;
          cnt_d     = LEN_W'(2);
          hdr_bad_d = hdr_bad_q | (data != 8'hD5);
          last_d    = {last_q[7:0], data};
        end else begin
          state_d = ST_IDLE;
          end_pkt = 1'b1;
        end
      end
      ST_BODY: begin
        if (dv) begin
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + LEN_W'(1);
          last_d = {last_q[7:0], data};
        end else begin
          state_d = ST_IDLE;
          end_pkt = 1'b1;
        end
      end
      default: state_d = ST_GAP;
    endcase

    if (end_pkt) begin
      if (cnt_q < LEN_W'(2) || hdr_bad_q) pulse_d = 5'b10000;
      else if (cnt_q < CNT_MIN)           pulse_d = 5'b01000;
      else if (cnt_q > CNT_MAX)           pulse_d = 5'b00100;
      else if (last_q != 16'hFD0D)        pulse_d = 5'b00010;
      else                                pulse_d = 5'b00001;
    end

    // A port change abandons the packet in flight without classifying it
    if (port_switch) begin
      state_d = ST_GAP;
      pulse_d = 5'b0;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q             <= ST_GAP;
      cnt_q               <= '0;
      hdr_bad_q           <= 1'b0;
      last_q              <= 16'h0000;
      spt_cpuif_head_err  <= 1'b0;
      spt_cpuif_short_pkt <= 1'b0;
      spt_cpuif_long_pkt  <= 1'b0;
      spt_cpuif_tail_err  <= 1'b0;
      spt_cpuif_ok_pkt    <= 1'b0;
      spt_busy            <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      hdr_bad_q           <= hdr_bad_d;
      last_q              <= last_d;
      spt_cpuif_head_err  <= pulse_d[4];
      spt_cpuif_short_pkt <= pulse_d[3];
      spt_cpuif_long_pkt  <= pulse_d[2];
      spt_cpuif_tail_err  <= pulse_d[1];
      spt_cpuif_ok_pkt    <= pulse_d[0];
      spt_busy            <= (state_d == ST_HEAD) || (state_d == ST_BODY);
    end
  end

endmodule

// File: tb/tb_spt_pkt_chk.sv
// Self-checking bench for spt_pkt_chk: vector table, corner sequences and randomized packets vs. a packet-level model.
module tb_spt_pkt_chk;

  localparam int MIN_LEN = 8;
  localparam int MAX_LEN = 1518;
  localparam int LEN_W   = 12;

  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_HEAD  = 5'b10000;
  localparam logic [4:0] P_SHORT = 5'b01000;
  localparam logic [4:0] P_LONG  = 5'b00100;
  localparam logic [4:0] P_TAIL  = 5'b00010;
  localparam logic [4:0] P_OK    = 5'b00001;

  logic       clk_50m = 1'b0;
  logic       rst_core_n = 1'b0;
  logic       cpuif_port_sel = 1'b0;
  logic       rxa_dv = 1'b0;
  logic [7:0] rxa_data = 8'h00;
  logic       rxb_dv = 1'b0;
  logic [7:0] rxb_data = 8'h00;
  logic       spt_cpuif_head_err, spt_cpuif_tail_err, spt_cpuif_short_pkt;
  logic       spt_cpuif_long_pkt, spt_cpuif_ok_pkt, spt_busy;

  spt_pkt_chk #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_50m            (clk_50m),
    .rst_core_n         (rst_core_n),
    .cpuif_port_sel     (cpuif_port_sel),
    .rxa_dv             (rxa_dv),
    .rxa_data           (rxa_data),
    .rxb_dv             (rxb_dv),
    .rxb_data           (rxb_data),
    .spt_cpuif_head_err (spt_cpuif_head_err),
    .spt_cpuif_tail_err (spt_cpuif_tail_err),
    .spt_cpuif_short_pkt(spt_cpuif_short_pkt),
    .spt_cpuif_long_pkt (spt_cpuif_long_pkt),
    .spt_cpuif_ok_pkt   (spt_cpuif_ok_pkt),
    .spt_busy           (spt_busy)
  );

  always #10 clk_50m = ~clk_50m;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] obs;
  logic       obs_busy;
  logic [7:0] pkt[$];

  typedef struct {
    string      name;
    int         len;
    logic [7:0] h1;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string n, input int l, input logic [7:0] h1,
                              input logic [7:0] t0, input logic [7:0] t1, input logic [4:0] e);
    vec_t v;
    v.name = n; v.len = l; v.h1 = h1; v.t0 = t0; v.t1 = t1; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample just after the rising edge
  task automatic drive(input logic a_dv, input logic [7:0] a_d, input logic b_dv, input logic [7:0] b_d);
    @(negedge clk_50m);
    rxa_dv = a_dv; rxa_data = a_d; rxb_dv = b_dv; rxb_data = b_d;
    @(posedge clk_50m);
    #1;
    obs = {spt_cpuif_head_err, spt_cpuif_short_pkt, spt_cpuif_long_pkt,
           spt_cpuif_tail_err, spt_cpuif_ok_pkt};
    obs_busy = spt_busy;
  endtask

  task automatic build(input int len, input logic [7:0] h1, input logic [7:0] t0, input logic [7:0] t1);
    pkt.delete();
    for (int i = 0; i < len; i++) begin
      if (i == 0)            pkt.push_back(8'h55);
      else if (i == 1)       pkt.push_back(h1);
      else if (i == len - 2) pkt.push_back(t0);
      else if (i == len - 1) pkt.push_back(t1);
      else                   pkt.push_back(8'(i));
    end
  endtask

  // Reference classification straight from the packet contents
  function automatic logic [4:0] classify();
    int n = pkt.size();
    if (n < 2 || pkt[0] != 8'h55 || pkt[1] != 8'hD5) return P_HEAD;
    if (n < MIN_LEN) return P_SHORT;
    if (n > MAX_LEN) return P_LONG;
    if (pkt[n-2] != 8'hFD || pkt[n-1] != 8'h0D) return P_TAIL;
    return P_OK;
  endfunction

  task automatic send_pkt(input string name, input logic on_b, input int gap, input logic [4:0] exp);
    int         npulse = 0;
    logic [4:0] at_end = P_NONE;
    logic       busy_first = 1'b0;
    logic       busy_end = 1'b1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (on_b) drive(1'b0, 8'h00, 1'b1, pkt[i]);
      else      drive(1'b1, pkt[i], 1'b0, 8'h00);
      if (obs != P_NONE) npulse++;
      if (i == 0) busy_first = obs_busy;
    end
    for (int g = 0; g < gap; g++) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      if (obs != P_NONE) npulse++;
      if (g == 0) begin
        at_end   = obs;
        busy_end = obs_busy;
      end
    end
    check({name, " pulse"}, 32'(at_end), 32'(exp));
    check({name, " npulse"}, 32'(npulse), 32'd1);
    check({name, " busy_rise"}, 32'(busy_first), 32'd1);
    check({name, " busy_fall"}, 32'(busy_end), 32'd0);
  endtask

  initial begin
    int len;
    int npulse;
    logic [4:0] at_end;

    vecs[0]  = mk("ok10",      10,   8'hD5, 8'hFD, 8'h0D, P_OK);
    vecs[1]  = mk("hdr_d4",    20,   8'hD4, 8'hFD, 8'h0D, P_HEAD);
    vecs[2]  = mk("len1",      1,    8'hD5, 8'hFD, 8'h0D, P_HEAD);
    vecs[3]  = mk("short6",    6,    8'hD5, 8'hFD, 8'h0D, P_SHORT);
    vecs[4]  = mk("long1600",  1600, 8'hD5, 8'hFD, 8'h0D, P_LONG);
    vecs[5]  = mk("tail_swap", 12,   8'hD5, 8'h0D, 8'hFD, P_TAIL);
    vecs[6]  = mk("min8",      8,    8'hD5, 8'hFD, 8'h0D, P_OK);
    vecs[7]  = mk("short7",    7,    8'hD5, 8'hFD, 8'h0D, P_SHORT);
    vecs[8]  = mk("max1518",   1518, 8'hD5, 8'hFD, 8'h0D, P_OK);
    vecs[9]  = mk("long1519",  1519, 8'hD5, 8'hFD, 8'h0D, P_LONG);
    vecs[10] = mk("len2",      2,    8'hD5, 8'hFD, 8'h0D, P_SHORT);
    vecs[11] = mk("sat4200",   4200, 8'hD5, 8'hFD, 8'h0D, P_LONG);
    vecs[12] = mk("tail_0c",   8,    8'hD5, 8'hFD, 8'h0C, P_TAIL);

    // Reset values
    repeat (2) @(posedge clk_50m);
    #1;
    check("reset pulses", 32'({spt_cpuif_head_err, spt_cpuif_short_pkt, spt_cpuif_long_pkt,
                               spt_cpuif_tail_err, spt_cpuif_ok_pkt}), 32'd0);
    check("reset busy", 32'(spt_busy), 32'd0);
    @(negedge clk_50m);
    rst_core_n = 1'b1;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 8'h00);

    foreach (vecs[k]) begin
      build(vecs[k].len, vecs[k].h1, vecs[k].t0, vecs[k].t1);
      send_pkt(vecs[k].name, 1'b0, 2, vecs[k].exp);
    end

    // Exact 10-byte sequence with a 1-cycle gap, then a back-to-back packet
    pkt = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFD, 8'h0D, 8'hFD, 8'h0D};
    send_pkt("seq10", 1'b0, 1, P_OK);
    build(9, 8'hD5, 8'hFD, 8'h0D);
    send_pkt("b2b9", 1'b0, 1, P_OK);
    pkt = '{8'h55};
    send_pkt("b2b_len1", 1'b0, 1, P_HEAD);
    drive(1'b0, 8'h00, 1'b0, 8'h00);

`ifdef SPT_PORT_B_EN
    // Switch A->B while both ports are mid-run: no pulse, then a clean B packet
    npulse = 0;
    cpuif_port_sel = 1'b0;
    drive(1'b1, 8'h55, 1'b1, 8'h11);
    drive(1'b1, 8'hD5, 1'b1, 8'h22);
    drive(1'b1, 8'h01, 1'b1, 8'h33);
    check("sw busy_before", 32'(obs_busy), 32'd1);
    cpuif_port_sel = 1'b1;
    drive(1'b1, 8'h02, 1'b1, 8'h44);
    if (obs != P_NONE) npulse++;
    check("sw busy_after", 32'(obs_busy), 32'd0);
    repeat (3) begin
      drive(1'b1, 8'h03, 1'b1, 8'h55);
      if (obs != P_NONE) npulse++;
    end
    repeat (2) begin
      drive(1'b1, 8'h03, 1'b0, 8'h00);
      if (obs != P_NONE) npulse++;
    end
    check("sw abort npulse", 32'(npulse), 32'd0);
    build(10, 8'hD5, 8'hFD, 8'h0D);
    send_pkt("sw b_ok", 1'b1, 2, P_OK);
    cpuif_port_sel = 1'b0;
    repeat (2) drive(1'b0, 8'h00, 1'b0, 8'h00);
`else
    // Port select and port B are ignored: toggle mid-packet, A still classified
    npulse = 0;
    build(12, 8'hD5, 8'hFD, 8'h0D);
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == 4) cpuif_port_sel = 1'b1;
      drive(1'b1, pkt[i], 1'b1, 8'hEE);
      if (obs != P_NONE) npulse++;
    end
    drive(1'b0, 8'h00, 1'b1, 8'hEE);
    at_end = obs;
    if (obs != P_NONE) npulse++;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    if (obs != P_NONE) npulse++;
    check("sel_ignored pulse", 32'(at_end), 32'(P_OK));
    check("sel_ignored npulse", 32'(npulse), 32'd1);
    npulse = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      drive(1'b0, 8'h00, 1'b1, pkt[i]);
      if (obs != P_NONE || obs_busy) npulse++;
    end
    repeat (2) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      if (obs != P_NONE || obs_busy) npulse++;
    end
    check("port_b_ignored", 32'(npulse), 32'd0);
    cpuif_port_sel = 1'b0;
`endif

    // Randomized packets against the model
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(1510, 1530);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      if ($urandom_range(0, 4) != 0) pkt[0] = 8'h55;
      if (len >= 2 && $urandom_range(0, 4) != 0) pkt[1] = 8'hD5;
      if (len >= 4 && $urandom_range(0, 3) != 0) begin
        pkt[len-2] = 8'hFD;
        pkt[len-1] = 8'h0D;
      end
      send_pkt($sformatf("rnd%0d", r), 1'b0, $urandom_range(1, 3), classify());
    end

    // Reset in the middle of a packet with dv held high
    npulse = 0;
    build(10, 8'hD5, 8'hFD, 8'h0D);
    for (int i = 0; i < 5; i++) drive(1'b1, pkt[i], 1'b0, 8'h00);
    @(negedge clk_50m);
    #2 rst_core_n = 1'b0;
    #1;
    check("rst_mid async", 32'({spt_cpuif_head_err, spt_cpuif_short_pkt, spt_cpuif_long_pkt,
                                spt_cpuif_tail_err, spt_cpuif_ok_pkt, spt_busy}), 32'd0);
    repeat (3) begin
      drive(1'b1, 8'hAA, 1'b0, 8'h00);
      if (obs != P_NONE || obs_busy) npulse++;
    end
    @(negedge clk_50m);
    rst_core_n = 1'b1;
    repeat (2) begin
      drive(1'b1, 8'hAA, 1'b0, 8'h00);
      if (obs != P_NONE || obs_busy) npulse++;
    end
    repeat (2) begin
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      if (obs != P_NONE || obs_busy) npulse++;
    end
    check("rst_mid quiet", 32'(npulse), 32'd0);
    build(10, 8'hD5, 8'hFD, 8'h0D);
    send_pkt("post_rst", 1'b0, 2, P_OK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spt_pkt_chk.md
# spt_pkt_chk

Packet checker feeding the CPU interface's packet-statistics counters. It takes two byte-wide receive ports (A/B) and uses the CPU-selected port. It frames each packet as a contiguous run of data-valid bytes and checks header, length and tail. At every packet end it emits exactly one single-cycle classification pulse (head error, short, long, tail error or OK) on `clk_50m`. The CPU interface edge-detects and counts these pulses.

## Interface
Parameters:
- `MIN_LEN`, default 8: minimum legal total packet length in bytes, header and tail included; must be ≥4.
- `MAX_LEN`, default 1518: maximum legal total packet length in bytes; must be < 2^`LEN_W`−1.
- `LEN_W`, default 12: width of the byte counter.

Ports:
- `clk_50m`, input, 1: clock.
- `rst_core_n`, input, 1: reset, asynchronous, active-low.
- `cpuif_port_sel`, input, 1: 0 selects port A, 1 selects port B.
- `rxa_dv`, input, 1: port A data valid.
- `rxa_data`, input, 8: port A byte.
- `rxb_dv`, input, 1: port B data valid.
- `rxb_data`, input, 8: port B byte.
- `spt_cpuif_head_err`, output, 1: header-error pulse.
- `spt_cpuif_tail_err`, output, 1: tail-error pulse.
- `spt_cpuif_short_pkt`, output, 1: short-packet pulse.
- `spt_cpuif_long_pkt`, output, 1: long-packet pulse.
- `spt_cpuif_ok_pkt`, output, 1: good-packet pulse.
- `spt_busy`, output, 1: high while a packet is being received (state HEAD or BODY).

## Operation
Selected port: `dv`/`data` are the muxed signals from port A or port B, chosen by `cpuif_port_sel`. Inputs are synchronous to `clk_50m`.

Packet format:
- Byte0 = 0x55, byte1 = 0xD5 (header).
- Payload of any length follows.
- The last two bytes = 0xFD, 0x0D (tail).

State machine:
- **GAP**: wait for `dv`=0, then go to IDLE. This is the reset state, so a packet already in flight at reset or port switch is ignored.
- **IDLE**: on `dv`=1, capture byte0, set count=1, go to HEAD.
- **HEAD**: the byte0/byte1 compare is recorded in the `hdr_bad` flag.
  - If `dv`=1, capture byte1, set count=2, go to BODY.
  - If `dv`=0, end the packet with count=1, which is always classified head_err.
- **BODY**: while `dv`=1, increment count (saturating at MAX_LEN+1) and shift the data into a 2-byte last-bytes register. On `dv`=0, end the packet and go to IDLE.

Classification at packet end, first match wins, exactly one pulse:
1. head_err: count < 2, or `hdr_bad`.
2. short_pkt: count < MIN_LEN.
3. long_pkt: count > MAX_LEN.
4. tail_err: last two bytes ≠ {0xFD, 0x0D}.
5. ok_pkt: otherwise.

Port switch: a change of `cpuif_port_sel`, detected against a registered copy, forces GAP from any state. The aborted packet produces no pulse. Any pulse already scheduled for the current cycle still fires.

Width rule: the counter is `LEN_W` bits and saturating, so it never wraps.

## Timing
- Reset values: all five pulse outputs = 0, `spt_busy` = 0, state = GAP, count = 0, `hdr_bad` = 0, last-bytes register = 0x0000, `cpuif_port_sel` copy = 0.
- Packet end is the first cycle `dv` is sampled 0 after a run. The classification pulse is registered and is high for exactly 1 cycle, on the cycle after that end cycle.
- Back-to-back packets need a minimum gap of 1 idle cycle. A new packet may start in the same cycle as the previous packet's pulse.
- `spt_busy` rises the cycle after the first byte and falls the cycle after packet end.
- Reset mid-packet clears everything immediately. No pulse is produced. The checker then waits in GAP for `dv`=0.
- Pulses from consecutive packets are separated by at least 1 cycle low, so downstream edge detection sees each one.

## Configuration
- `SPT_PORT_B_EN` defined: dual-port mux as described; `cpuif_port_sel` selects the port and port switching aborts any packet in flight.
- `SPT_PORT_B_EN` undefined: only port A is used. `rxb_dv`/`rxb_data` and `cpuif_port_sel` are ignored and switch-abort logic is removed. The ports remain in the port list.

## Test plan
- 10-byte packet on A: 55 D5 01 02 03 04 FD 0D then 2 more bytes FD 0D, 1-cycle gap → `spt_cpuif_ok_pkt`=1 for exactly 1 cycle, 1 cycle after `dv` falls; all other pulses 0.
- Header byte1 = 0xD4, 20-byte packet → `spt_cpuif_head_err` only. 1-byte packet 0x55 → `spt_cpuif_head_err`.
- 6-byte packet 55 D5 00 00 FD 0D → `spt_cpuif_short_pkt`. 1600-byte packet with valid header and tail → `spt_cpuif_long_pkt`.
- 12-byte packet with valid header ending 0D FD → `spt_cpuif_tail_err`.
- `cpuif_port_sel` toggled 0→1 mid-packet on A while B is mid-run → no pulse. The next complete B packet, after a B gap, gives `spt_cpuif_ok_pkt`.
- `rst_core_n` asserted mid-packet for 3 cycles with `dv` still high → outputs 0 and no pulse. A subsequent good packet after a gap gives exactly one ok pulse.
